// File: rtl/regfile_write_sequencer.sv
// In-order write queue feeding the 32-entry register array: one registered one-hot row enable per cycle.
// Optional build macro REGWRITE_ZERO_DISCARD_EN: writes to register 0 are queued but never enabled.
module regfile_write_sequencer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [4:0]               wr_address,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     stall,
  output logic [31:0]              enable,
  output logic [WIDTH-1:0]         data_out,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

`ifdef REGWRITE_ZERO_DISCARD_EN
  localparam bit DISCARD_ZERO = 1'b1;
`else
  localparam bit DISCARD_ZERO = 1'b0;
`endif

  logic [4:0]       addr_mem_q [DEPTH];
  logic [WIDTH-1:0] data_mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      enable_q, enable_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             push, pop;

  function automatic logic [31:0] onehot(input logic [4:0] a);
    onehot = 32'd1 << a;
  endfunction

  function automatic logic is_discarded(input logic [4:0] a);
    return DISCARD_ZERO && (a == 5'd0);
  endfunction

  // Ready depends on occupancy only, so a full queue never accepts even while popping.
  assign wr_ready = rst_n && (count_q < DEPTH_C);
  assign push     = wr_valid && wr_ready;
  assign pop      = (count_q != '0) && !stall;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    enable_d   = '0;
    data_out_d = data_out_q;
    if (pop) begin
      head_d = head_q + PTR_W'(1);
      if (!is_discarded(addr_mem_q[head_q])) begin
        enable_d   = onehot(addr_mem_q[head_q]);
        data_out_d = data_mem_q[head_q];
      end
    end
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      enable_q   <= '0;
      data_out_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      enable_q   <= enable_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[tail_q] <= wr_address;
      data_mem_q[tail_q] <= wr_data;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q) begin
        pending = pending | onehot(addr_mem_q[head_q + PTR_W'(i)]);
      end
    end
    if (DISCARD_ZERO) begin
      pending[0] = 1'b0;
    end
  end

  assign enable   = enable_q;
  assign data_out = data_out_q;
  assign count    = count_q;

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Bench for regfile_write_sequencer: address-sweep vector table, scoreboard of retirements, corner sequences.
module tb_regfile_write_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [4:0]  wr_address = '0;
  logic [31:0] wr_data = '0;
  logic        stall = 1'b0;
  logic [31:0] enable;
  logic [31:0] data_out;
  logic [31:0] pending;
  logic [1:0]  count;

  regfile_write_sequencer #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_address(wr_address), .wr_data(wr_data), .stall(stall),
    .enable(enable), .data_out(data_out), .pending(pending), .count(count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_en;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [31:0] en;
    logic [31:0] data;
    int          cyc;
  } sb_t;

  vec_t vecs[32];
  sb_t  sb[$];
  sb_t  mon_it;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Retirement monitor: every enable pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && enable != 32'd0) begin
      chk("enable_onehot", enable & (enable - 32'd1), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_enable: got %h expected no pulse (cycle %0d)", enable, cyc);
      end else begin
        mon_it = sb.pop_front();
        chk("ret_enable", enable, mon_it.en);
        chk("ret_data", data_out, mon_it.data);
        if (mon_it.cyc >= 0) chk("ret_cycle", cyc, mon_it.cyc);
      end
    end
  end

  // Called at a negedge; holds the request until accepted, returns at the negedge after the accepting edge.
  task automatic accept_now(input logic [4:0] a, input logic [31:0] d,
                            input logic [31:0] een, input logic [31:0] edat, input int lat);
    sb_t it;
    wr_valid   = 1'b1;
    wr_address = a;
    wr_data    = d;
    for (int t = 0; t < 100 && !wr_ready; t++) @(negedge clk);
    if (!wr_ready) begin
      chk("accept_timeout", {31'd0, wr_ready}, 32'd1);
    end else begin
      it.en   = een;
      it.data = edat;
      it.cyc  = (lat < 0) ? -1 : cyc + lat;
      if (een != 32'd0) sb.push_back(it);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (sb.size() == 0 && count == 2'd0) break;
      @(negedge clk);
    end
    chk("drain_done", {31'd0, (sb.size() == 0 && count == 2'd0)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      vecs[i].addr     = 5'(i);
      vecs[i].data     = {8'hA0 + 8'(i), 24'(i * 7919 + 3)};
      vecs[i].exp_en   = 32'd1 << i;
      vecs[i].exp_data = vecs[i].data;
`ifdef REGWRITE_ZERO_DISCARD_EN
      if (i == 0) vecs[i].exp_en = 32'd0;
`endif
    end

    // Reset with a request asserted
    wr_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_enable", enable, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_count", {30'd0, count}, 32'd0);
    chk("rst_pending", pending, 32'd0);
    wr_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("rel_wr_ready", {31'd0, wr_ready}, 32'd1);
    @(negedge clk);

    // Single write, two-edge latency, one-cycle pulse
    accept_now(5'd5, 32'hDEADBEEF, 32'h00000020, 32'hDEADBEEF, 2);
    wr_valid = 1'b0;
    chk("single_pending", pending, 32'h00000020);
    chk("single_count", {30'd0, count}, 32'd1);
    @(negedge clk);
    chk("single_enable", enable, 32'h00000020);
    chk("single_pending_clr", pending, 32'd0);
    @(negedge clk);
    chk("single_enable_off", enable, 32'd0);
    chk("single_data_hold", data_out, 32'hDEADBEEF);
    drain();

    // Back-to-back address sweep, one retirement per cycle
    for (int i = 0; i < 32; i++)
      accept_now(vecs[i].addr, vecs[i].data, vecs[i].exp_en, vecs[i].exp_data, 2);
    wr_valid = 1'b0;
    drain();

    // Stall with a full queue
    stall = 1'b1;
    accept_now(5'd3, 32'h33333333, 32'd1 << 3, 32'h33333333, -1);
    accept_now(5'd7, 32'h77777777, 32'd1 << 7, 32'h77777777, -1);
    wr_valid   = 1'b1;
    wr_address = 5'd12;
    wr_data    = 32'hCCCCCCCC;
    chk("full_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("full_count", {30'd0, count}, 32'd2);
    chk("full_pending", pending, (32'd1 << 3) | (32'd1 << 7));
    @(negedge clk);
    chk("stalled_count", {30'd0, count}, 32'd2);
    chk("stalled_enable", enable, 32'd0);
    stall = 1'b0;
    @(negedge clk);
    chk("unstall_wr_ready", {31'd0, wr_ready}, 32'd1);
    accept_now(5'd12, 32'hCCCCCCCC, 32'd1 << 12, 32'hCCCCCCCC, -1);
    wr_valid = 1'b0;
    drain();

    // Repeated writes to one register
    accept_now(5'd9, 32'h1, 32'd1 << 9, 32'h1, 2);
    chk("rep_pending_a", {31'd0, pending[9]}, 32'd1);
    accept_now(5'd9, 32'h2, 32'd1 << 9, 32'h2, 2);
    wr_valid = 1'b0;
    chk("rep_pending_b", {31'd0, pending[9]}, 32'd1);
    @(negedge clk);
    chk("rep_pending_clr", pending, 32'd0);
    drain();

    // Asynchronous reset while a write is on enable and another is queued
    stall = 1'b1;
    accept_now(5'd1, 32'h11110000, 32'd1 << 1, 32'h11110000, -1);
    accept_now(5'd2, 32'h22220000, 32'd1 << 2, 32'h22220000, -1);
    wr_valid = 1'b0;
    chk("prerst_count", {30'd0, count}, 32'd2);
    stall = 1'b0;
    @(posedge clk);
    #1;
    chk("prerst_enable", enable, 32'h00000002);
    chk("prerst_pending", pending, 32'h00000004);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_enable", enable, 32'd0);
    chk("midrst_pending", pending, 32'd0);
    chk("midrst_count", {30'd0, count}, 32'd0);
    chk("midrst_wr_ready", {31'd0, wr_ready}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("postrst_enable", enable, 32'd0);
      chk("postrst_count", {30'd0, count}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
